// File: rtl/heap_feeder.sv
// -----------------------------------------------------------------------------
// heap_feeder
//
// Frame-level front end for the heap sorter. Accepts a valid/ready stream of
// (payload, key) entries, clears the heap at frame start, paces single-cycle
// insert pulses so that at least GAP idle cycles follow each insert, flushes
// the heap at end of frame and counts the drained entries until every
// retained entry has left.
//
// Parameters:
//   DATA_WIDTH  entry width; key in [KEY_WIDTH-1:0], payload in the upper bits
//   KEY_WIDTH   key field width
//   NLEVELS     heap levels; capacity CAP = 2^NLEVELS - 1
//   GAP         idle cycles required after each insert pulse (1..15)
//
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   frame_start  frame start pulse (honoured only in IDLE)
//   s_valid / s_ready / s_data / s_last   upstream entry stream
//   heap_din, heap_en, heap_init, heap_flush   heap controls
//   heap_valid   heap emitted one sorted entry this cycle
//   busy         high in every state except IDLE
//   frame_done   one-cycle pulse when the drain is complete
//   overflow     sticky: more than CAP entries accepted this frame
//   accepted     entries accepted this frame (saturating)
//
// Every output is a register.
// -----------------------------------------------------------------------------
module heap_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int KEY_WIDTH  = 4,
  parameter int NLEVELS    = 3,
  parameter int GAP        = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  frame_start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic [DATA_WIDTH-1:0] heap_din,
  output logic                  heap_en,
  output logic                  heap_init,
  output logic                  heap_flush,
  input  logic                  heap_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow,
  output logic [15:0]           accepted
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_INIT  = 3'd1;
  localparam logic [2:0] ST_FILL  = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // CAP = 2^NLEVELS - 1 is exactly the all-ones value of an NLEVELS-bit word.
  localparam logic [NLEVELS-1:0] CAP_N    = '1;
  localparam logic [15:0]        CAP_16   = 16'((1 << NLEVELS) - 1);
  localparam logic [3:0]         GAP_LOAD = 4'(GAP);

  logic [2:0]            state_reg, state_next;
  logic [3:0]            gap_reg, gap_next;
  logic [NLEVELS-1:0]    drain_reg, drain_next;
  logic [NLEVELS-1:0]    drain_inc;
  logic [NLEVELS-1:0]    expected;
  logic [15:0]           accepted_reg, accepted_next;
  logic                  overflow_reg, overflow_next;
  logic [DATA_WIDTH-1:0] heap_din_reg, heap_din_next;
  logic                  s_ready_reg, heap_en_reg, heap_init_reg, heap_flush_reg;
  logic                  busy_reg, frame_done_reg;
  logic                  accept;

  // Key and payload are kept as named fields so the entry layout the heap
  // compares on is explicit; the heap sees them re-packed in the same order.
  logic [KEY_WIDTH-1:0]            s_key;
  logic [DATA_WIDTH-KEY_WIDTH-1:0] s_payload;
  assign s_key     = s_data[KEY_WIDTH-1:0];
  assign s_payload = s_data[DATA_WIDTH-1:KEY_WIDTH];

  assign accept    = (state_reg == ST_FILL) && s_ready_reg && s_valid;
  assign drain_inc = drain_reg + 1'b1;
  // Only min(accepted, CAP) entries can come back out of the heap.
  assign expected  = (accepted_reg >= CAP_16) ? CAP_N : accepted_reg[NLEVELS-1:0];

  always_comb begin
    state_next    = state_reg;
    gap_next      = (gap_reg != 4'd0) ? gap_reg - 4'd1 : 4'd0;
    drain_next    = drain_reg;
    accepted_next = accepted_reg;
    overflow_next = overflow_reg;
    heap_din_next = heap_din_reg;

    case (state_reg)
      ST_IDLE: begin
        if (frame_start) begin
          // Frame bookkeeping is cleared on the way into INIT so the INIT
          // cycle already shows a fresh frame.
          state_next    = ST_INIT;
          gap_next      = 4'd0;
          drain_next    = '0;
          accepted_next = 16'd0;
          overflow_next = 1'b0;
        end
      end
      ST_INIT: begin
        state_next = ST_FILL;
      end
      ST_FILL: begin
        if (accept) begin
          gap_next      = GAP_LOAD;
          heap_din_next = {s_payload, s_key};
          if (accepted_reg != 16'hFFFF) begin
            accepted_next = accepted_reg + 16'd1;
          end
          if (accepted_reg == CAP_16) begin
            overflow_next = 1'b1;
          end
          if (s_last) begin
            state_next = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // heap_flush is high during this last FLUSH cycle (see output regs).
        if (gap_reg == 4'd0) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_reg == expected) begin
          state_next = ST_DONE;
        end else if (heap_valid) begin
          drain_next = drain_inc;
          // Leave in the same cycle as the final pulse so frame_done
          // follows it immediately.
          if (drain_inc == expected) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= ST_IDLE;
      gap_reg        <= 4'd0;
      drain_reg      <= '0;
      accepted_reg   <= 16'd0;
      overflow_reg   <= 1'b0;
      heap_din_reg   <= '0;
      s_ready_reg    <= 1'b0;
      heap_en_reg    <= 1'b0;
      heap_init_reg  <= 1'b0;
      heap_flush_reg <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      gap_reg        <= gap_next;
      drain_reg      <= drain_next;
      accepted_reg   <= accepted_next;
      overflow_reg   <= overflow_next;
      heap_din_reg   <= heap_din_next;
      // Output flags are decoded from the next state so they line up with
      // the state they describe while still coming straight from flops.
      s_ready_reg    <= (state_next == ST_FILL) && (gap_next == 4'd0);
      heap_en_reg    <= accept;
      heap_init_reg  <= (state_next == ST_INIT);
      heap_flush_reg <= (state_next == ST_FLUSH) && (gap_next == 4'd0);
      busy_reg       <= (state_next != ST_IDLE);
      frame_done_reg <= (state_next == ST_DONE);
    end
  end

  assign s_ready    = s_ready_reg;
  assign heap_din   = heap_din_reg;
  assign heap_en    = heap_en_reg;
  assign heap_init  = heap_init_reg;
  assign heap_flush = heap_flush_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign overflow   = overflow_reg;
  assign accepted   = accepted_reg;

endmodule

// File: tb/tb_heap_feeder.sv
// Self-checking bench for heap_feeder: a cycle table for the basic frame on a
// GAP=1 instance, then hand-written sequences for overflow, one-entry frame,
// reset during drain, stalled upstream, and a GAP=3 instance.
module tb_heap_feeder;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // GAP = 1 instance
  logic       frame_start, s_valid, s_ready, s_last;
  logic [7:0] s_data, heap_din;
  logic       heap_en, heap_init, heap_flush, heap_valid;
  logic       busy, frame_done, overflow;
  logic [15:0] accepted;

  heap_feeder #(.DATA_WIDTH(8), .KEY_WIDTH(4), .NLEVELS(3), .GAP(1)) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .heap_din(heap_din), .heap_en(heap_en), .heap_init(heap_init),
    .heap_flush(heap_flush), .heap_valid(heap_valid), .busy(busy),
    .frame_done(frame_done), .overflow(overflow), .accepted(accepted)
  );

  // GAP = 3 instance
  logic       fs3, sv3, rdy3, sl3;
  logic [7:0] sd3, din3;
  logic       en3, init3, flush3, hv3, busy3, done3, ovf3;
  logic [15:0] acc3;

  heap_feeder #(.DATA_WIDTH(8), .KEY_WIDTH(4), .NLEVELS(3), .GAP(3)) dut3 (
    .clk(clk), .rstn(rstn), .frame_start(fs3),
    .s_valid(sv3), .s_ready(rdy3), .s_data(sd3), .s_last(sl3),
    .heap_din(din3), .heap_en(en3), .heap_init(init3),
    .heap_flush(flush3), .heap_valid(hv3), .busy(busy3),
    .frame_done(done3), .overflow(ovf3), .accepted(acc3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One row per cycle: inputs driven in that cycle, outputs expected in it.
  typedef struct packed {
    logic        fs, sv;
    logic [7:0]  sd;
    logic        sl, hv;
    logic        rdy, en;
    logic [7:0]  din;
    logic        init, flush, bsy, done, ovf;
    logic [15:0] acc;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic wait_ready();
    int t = 0;
    while (!s_ready && t < 50) begin
      tick();
      t++;
    end
    chk("ready_timeout", 32'(t < 50), 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    wait_ready();
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    $display("send %02h last=%0d accepted=%0d", d, last, accepted);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("start_init", 32'(heap_init), 32'd1);
    chk("start_acc0", 32'(accepted), 32'd0);
    tick();
  endtask

  task automatic wait_flush();
    int t = 0;
    while (!heap_flush && t < 50) begin
      tick();
      t++;
    end
    chk("flush_timeout", 32'(t < 50), 32'd1);
    tick();
  endtask

  task automatic pulse_hv(input int n);
    for (int k = 0; k < n; k++) begin
      heap_valid = 1'b1;
      tick();
      heap_valid = 1'b0;
    end
  endtask

  initial begin
    int hs;
    logic prev_en;

    rstn = 1'b0;
    frame_start = 0; s_valid = 0; s_data = 0; s_last = 0; heap_valid = 0;
    fs3 = 0; sv3 = 0; sd3 = 0; sl3 = 0; hv3 = 0;

    //            fs sv sd     sl hv rdy en din   in fl by dn ov acc
    vecs[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd0};
    vecs[1]  = '{1'b0,1'b1,8'hA9,1'b0,1'b0, 1'b0,1'b0,8'h00, 1'b1,1'b0,1'b1,1'b0,1'b0,16'd0};
    vecs[2]  = '{1'b0,1'b1,8'hA9,1'b0,1'b0, 1'b1,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b0,1'b0,16'd0};
    vecs[3]  = '{1'b0,1'b1,8'hB3,1'b0,1'b0, 1'b0,1'b1,8'hA9, 1'b0,1'b0,1'b1,1'b0,1'b0,16'd1};
    vecs[4]  = '{1'b0,1'b1,8'hB3,1'b0,1'b0, 1'b1,1'b0,8'hA9, 1'b0,1'b0,1'b1,1'b0,1'b0,16'd1};
    vecs[5]  = '{1'b0,1'b1,8'hCC,1'b0,1'b0, 1'b0,1'b1,8'hB3, 1'b0,1'b0,1'b1,1'b0,1'b0,16'd2};
    vecs[6]  = '{1'b0,1'b1,8'hCC,1'b0,1'b0, 1'b1,1'b0,8'hB3, 1'b0,1'b0,1'b1,1'b0,1'b0,16'd2};
    vecs[7]  = '{1'b0,1'b1,8'hD5,1'b1,1'b0, 1'b0,1'b1,8'hCC, 1'b0,1'b0,1'b1,1'b0,1'b0,16'd3};
    vecs[8]  = '{1'b0,1'b1,8'hD5,1'b1,1'b0, 1'b1,1'b0,8'hCC, 1'b0,1'b0,1'b1,1'b0,1'b0,16'd3};
    vecs[9]  = '{1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b1,8'hD5, 1'b0,1'b0,1'b1,1'b0,1'b0,16'd4};
    vecs[10] = '{1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'hD5, 1'b0,1'b1,1'b1,1'b0,1'b0,16'd4};
    vecs[11] = '{1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,8'hD5, 1'b0,1'b0,1'b1,1'b0,1'b0,16'd4};
    vecs[12] = '{1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'hD5, 1'b0,1'b0,1'b1,1'b0,1'b0,16'd4};
    vecs[13] = '{1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,8'hD5, 1'b0,1'b0,1'b1,1'b0,1'b0,16'd4};
    vecs[14] = '{1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,8'hD5, 1'b0,1'b0,1'b1,1'b0,1'b0,16'd4};
    vecs[15] = '{1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,8'hD5, 1'b0,1'b0,1'b1,1'b0,1'b0,16'd4};
    vecs[16] = '{1'b0,1'b0,8'h00,1'b0,1'b1, 1'b0,1'b0,8'hD5, 1'b0,1'b0,1'b1,1'b1,1'b0,16'd4};
    vecs[17] = '{1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'hD5, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd4};
    vecs[18] = '{1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,8'hD5, 1'b0,1'b0,1'b0,1'b0,1'b0,16'd4};

    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // ---------------- basic frame, cycle table ----------------
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("v%0d_ready", i), 32'(s_ready),    32'(vecs[i].rdy));
      chk($sformatf("v%0d_en", i),    32'(heap_en),    32'(vecs[i].en));
      chk($sformatf("v%0d_din", i),   32'(heap_din),   32'(vecs[i].din));
      chk($sformatf("v%0d_init", i),  32'(heap_init),  32'(vecs[i].init));
      chk($sformatf("v%0d_flush", i), 32'(heap_flush), 32'(vecs[i].flush));
      chk($sformatf("v%0d_busy", i),  32'(busy),       32'(vecs[i].bsy));
      chk($sformatf("v%0d_done", i),  32'(frame_done), 32'(vecs[i].done));
      chk($sformatf("v%0d_ovf", i),   32'(overflow),   32'(vecs[i].ovf));
      chk($sformatf("v%0d_acc", i),   32'(accepted),   32'(vecs[i].acc));
      $display("vec %0d: en=%0d din=%02h flush=%0d done=%0d acc=%0d",
               i, heap_en, heap_din, heap_flush, frame_done, accepted);
      frame_start = vecs[i].fs;
      s_valid     = vecs[i].sv;
      s_data      = vecs[i].sd;
      s_last      = vecs[i].sl;
      heap_valid  = vecs[i].hv;
      tick();
    end
    frame_start = 0; s_valid = 0; s_data = 0; s_last = 0; heap_valid = 0;

    // ---------------- overflow: 10 entries ----------------
    start_frame();
    for (int i = 0; i < 10; i++) begin
      send(8'(8'h10 + i), 1'(i == 9));
      chk("ovf_en",  32'(heap_en),  32'd1);
      chk("ovf_din", 32'(heap_din), 32'(8'h10 + i));
      chk("ovf_acc", 32'(accepted), 32'(i + 1));
      chk("ovf_flag", 32'(overflow), 32'(i + 1 >= 8));
    end
    wait_flush();
    pulse_hv(6);
    chk("ovf_done_early", 32'(frame_done), 32'd0);
    pulse_hv(1);
    chk("ovf_done", 32'(frame_done), 32'd1);
    tick();
    chk("ovf_idle", 32'(busy), 32'd0);
    chk("ovf_acc_hold", 32'(accepted), 32'd10);
    chk("ovf_flag_hold", 32'(overflow), 32'd1);

    // ---------------- one-entry frame ----------------
    start_frame();
    send(8'h77, 1'b1);
    chk("one_en", 32'(heap_en), 32'd1);
    chk("one_din", 32'(heap_din), 32'h77);
    tick();
    chk("one_flush", 32'(heap_flush), 32'd1);
    tick();
    pulse_hv(1);
    chk("one_done", 32'(frame_done), 32'd1);
    chk("one_acc", 32'(accepted), 32'd1);
    tick();
    chk("one_idle", 32'(busy), 32'd0);

    // ---------------- reset in the middle of DRAIN ----------------
    start_frame();
    for (int i = 0; i < 5; i++) send(8'(8'h20 + i), 1'(i == 4));
    wait_flush();
    pulse_hv(2);
    chk("rst_pre_busy", 32'(busy), 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_en",    32'(heap_en), 32'd0);
    chk("rst_din",   32'(heap_din), 32'd0);
    chk("rst_init",  32'(heap_init), 32'd0);
    chk("rst_flush", 32'(heap_flush), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(frame_done), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_acc",   32'(accepted), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    chk("rst_still_idle", 32'(busy), 32'd0);
    start_frame();
    chk("rst_fill_ready", 32'(s_ready), 32'd1);

    // ---------------- stalled upstream (already in FILL) ----------------
    hs = 0;
    prev_en = 1'b0;
    for (int c = 0; c < 300 && hs < 6; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'(8'h40 + hs);
      s_last  = 1'(hs == 5);
      if (s_valid && s_ready) hs++;
      tick();
      chk("stall_acc", 32'(accepted), 32'(hs));
      chk("stall_en_b2b", 32'(prev_en & heap_en), 32'd0);
      prev_en = heap_en;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("stall_count", 32'(hs), 32'd6);
    $display("stall: %0d handshakes, accepted=%0d", hs, accepted);
    wait_flush();
    pulse_hv(6);
    chk("stall_done", 32'(frame_done), 32'd1);
    tick();

    // ---------------- GAP = 3 instance ----------------
    fs3 = 1'b1;
    tick();
    fs3 = 1'b0;
    chk("g3_init", 32'(init3), 32'd1);
    tick();
    chk("g3_ready0", 32'(rdy3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      sv3 = 1'b1;
      sd3 = 8'(8'h30 + i);
      sl3 = 1'(i == 2);
      tick();
      sv3 = 1'b0;
      sl3 = 1'b0;
      chk("g3_en", 32'(en3), 32'd1);
      chk("g3_din", 32'(din3), 32'(8'h30 + i));
      chk("g3_ready_low1", 32'(rdy3), 32'd0);
      for (int k = 0; k < 2; k++) begin
        tick();
        chk("g3_ready_low", 32'(rdy3), 32'd0);
        chk("g3_en_gap", 32'(en3), 32'd0);
        chk("g3_flush_gap", 32'(flush3), 32'd0);
      end
      tick();
      chk("g3_en_after", 32'(en3), 32'd0);
      if (i < 2) chk("g3_ready_back", 32'(rdy3), 32'd1);
      else       chk("g3_flush", 32'(flush3), 32'd1);
      $display("gap3 insert %0d din=%02h acc=%0d", i, din3, acc3);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      hv3 = 1'b1;
      tick();
      hv3 = 1'b0;
    end
    chk("g3_done", 32'(done3), 32'd1);
    chk("g3_acc", 32'(acc3), 32'd3);
    tick();
    chk("g3_idle", 32'(busy3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
